// File: rtl/smoosh_pkg.sv
// rtl/smoosh_pkg.sv - shared stage geometry, platform table and collision FSM states
package smoosh_pkg;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic [9:0] w;
    logic [9:0] h;
  } platform_t;

  localparam int NUM_PLATFORMS = 4;
  localparam int SCREEN_W      = 640;
  localparam int SCREEN_H      = 480;

  // main, left, right, top
  localparam platform_t PLATFORMS [0:NUM_PLATFORMS-1] = '{
    '{x: 10'd80,  y: 10'd400, w: 10'd480, h: 10'd16},
    '{x: 10'd140, y: 10'd300, w: 10'd120, h: 10'd8},
    '{x: 10'd380, y: 10'd300, w: 10'd120, h: 10'd8},
    '{x: 10'd260, y: 10'd200, w: 10'd120, h: 10'd8}
  };

  typedef enum logic [1:0] {
    COLL_IDLE,
    COLL_SCAN,
    COLL_DONE
  } coll_state_t;

endpackage

// File: rtl/box_classifier.sv
// rtl/box_classifier.sv - classifies one platform against the character box
// Exactly one of l/r/t/b is set under overlap, picked by the shallowest penetration.
module box_classifier
  import smoosh_pkg::*;
(
  input  logic [9:0] box_x,
  input  logic [9:0] box_y,
  input  logic [9:0] box_w,
  input  logic [9:0] box_h,
  input  platform_t  plat,
  output logic       hit_left,
  output logic       hit_right,
  output logic       hit_top,
  output logic       hit_bottom,
  output logic       touch
);

  // 11-bit edges so x+w never wraps
  logic [10:0] cx0, cx1, cy0, cy1;
  logic [10:0] px0, px1, py0, py1;
  logic [10:0] pb, pt, pl, pr;
  logic        h_ovl, overlap;

  always_comb begin
    cx0 = {1'b0, box_x};
    cy0 = {1'b0, box_y};
    cx1 = cx0 + {1'b0, box_w};
    cy1 = cy0 + {1'b0, box_h};
    px0 = {1'b0, plat.x};
    py0 = {1'b0, plat.y};
    px1 = px0 + {1'b0, plat.w};
    py1 = py0 + {1'b0, plat.h};

    h_ovl   = (cx0 < px1) && (cx1 > px0);
    overlap = h_ovl && (cy0 < py1) && (cy1 > py0);

    pb = cy1 - py0;
    pt = py1 - cy0;
    pl = px1 - cx0;
    pr = cx1 - px0;

    hit_left   = 1'b0;
    hit_right  = 1'b0;
    hit_top    = 1'b0;
    hit_bottom = 1'b0;
    // <= comparisons encode tie priority bottom > top > left > right
    if (overlap) begin
      if (pb <= pt && pb <= pl && pb <= pr)
        hit_bottom = 1'b1;
      else if (pt <= pl && pt <= pr)
        hit_top = 1'b1;
      else if (pl <= pr)
        hit_left = 1'b1;
      else
        hit_right = 1'b1;
    end

    touch = h_ovl && (cy1 == py0);
  end

endmodule

// File: rtl/collision_detector.sv
// rtl/collision_detector.sv - per-frame platform scan publishing registered collision flags
// One platform is classified per clock; results are published once per completed scan.
module collision_detector #(
  parameter int NUM_PLATFORMS = smoosh_pkg::NUM_PLATFORMS,
  parameter int SCREEN_W      = 640
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic [9:0] char_x,
  input  logic [9:0] char_y,
  input  logic [9:0] char_width,
  input  logic [9:0] char_height,
  output logic       collision_left,
  output logic       collision_right,
  output logic       collision_top,
  output logic       collision_bottom,
  output logic       is_grounded,
  output logic       collision_valid
);

  import smoosh_pkg::*;

  localparam int IDX_W = (NUM_PLATFORMS > 1) ? $clog2(NUM_PLATFORMS) : 1;

  coll_state_t state, state_next;

  logic [9:0]       snap_x, snap_y, snap_w, snap_h;
  logic [IDX_W-1:0] idx;
  logic             acc_l, acc_r, acc_t, acc_b, acc_g;
  logic             hit_l, hit_r, hit_t, hit_b, hit_touch;
  logic             last_idx, edge_l, edge_r;
  logic [10:0]      snap_x1;

  box_classifier u_classifier (
    .box_x      (snap_x),
    .box_y      (snap_y),
    .box_w      (snap_w),
    .box_h      (snap_h),
    .plat       (PLATFORMS[idx]),
    .hit_left   (hit_l),
    .hit_right  (hit_r),
    .hit_top    (hit_t),
    .hit_bottom (hit_b),
    .touch      (hit_touch)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= COLL_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    last_idx   = (idx == IDX_W'(NUM_PLATFORMS - 1));
    state_next = state;
    case (state)
      COLL_IDLE: if (frame_tick) state_next = COLL_SCAN;
      COLL_SCAN: if (last_idx)   state_next = COLL_DONE;
      COLL_DONE: state_next = COLL_IDLE;
      default:   state_next = COLL_IDLE;
    endcase
  end

  always_comb begin
    snap_x1 = {1'b0, snap_x} + {1'b0, snap_w};
    edge_l  = (snap_x == 10'd0);
    edge_r  = (snap_x1 >= 11'(SCREEN_W));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      snap_x           <= '0;
      snap_y           <= '0;
      snap_w           <= '0;
      snap_h           <= '0;
      idx              <= '0;
      acc_l            <= 1'b0;
      acc_r            <= 1'b0;
      acc_t            <= 1'b0;
      acc_b            <= 1'b0;
      acc_g            <= 1'b0;
      collision_left   <= 1'b0;
      collision_right  <= 1'b0;
      collision_top    <= 1'b0;
      collision_bottom <= 1'b0;
      is_grounded      <= 1'b0;
      collision_valid  <= 1'b0;
    end else begin
      collision_valid <= 1'b0;
      case (state)
        COLL_IDLE: begin
          if (frame_tick) begin
            snap_x <= char_x;
            snap_y <= char_y;
            snap_w <= char_width;
            snap_h <= char_height;
            idx    <= '0;
            acc_l  <= 1'b0;
            acc_r  <= 1'b0;
            acc_t  <= 1'b0;
            acc_b  <= 1'b0;
            acc_g  <= 1'b0;
          end
        end
        COLL_SCAN: begin
          acc_l <= acc_l | hit_l;
          acc_r <= acc_r | hit_r;
          acc_t <= acc_t | hit_t;
          acc_b <= acc_b | hit_b;
          acc_g <= acc_g | hit_touch | hit_b;
          if (!last_idx) idx <= idx + 1'b1;
        end
        COLL_DONE: begin
          collision_left   <= acc_l | edge_l;
          collision_right  <= acc_r | edge_r;
          collision_top    <= acc_t;
          collision_bottom <= acc_b;
          is_grounded      <= acc_g;
          collision_valid  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
